// File: rtl/regfile_mp.sv
// regfile_mp: multi-read-port register file with two prioritised write ports,
// r0 hardwired to zero and a multi-cycle clear sweep (busy / clr_done).
// Ports: clk, rst (async, active-low); we0/waddr0/wdata0 (low priority);
// we1/waddr1/wdata1 (high priority); raddr/rdata packed per read port;
// clr_req in; busy, clr_done out.
// Macro REGFILE_BYPASS_EN: forward same-cycle accepted write data to reads.
module regfile_mp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we0,
  input  logic [ADDR_W-1:0]        waddr0,
  input  logic [DATA_W-1:0]        wdata0,
  input  logic                     we1,
  input  logic [ADDR_W-1:0]        waddr1,
  input  logic [DATA_W-1:0]        wdata1,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  input  logic                     clr_req,
  output logic                     busy,
  output logic                     clr_done
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  logic wr_ok, wr0, wr1;

  // Writes are only locked out while the sweep is running.
  assign wr_ok = (state_q != SWEEP);
  assign wr0   = wr_ok & we0 & (waddr0 != '0);
  assign wr1   = wr_ok & we1 & (waddr1 != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d = SWEEP;
          cnt_d   = ADDR_W'(1);
        end
      end
      SWEEP: begin
        // Stop at the top entry so the counter never wraps.
        if (cnt_q == LAST) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    busy     = (state_q == SWEEP);
    clr_done = (state_q == DONE);
  end

  // Port 1 is applied last so it wins a same-address conflict.
  always_comb begin
    mem_d = mem_q;
    if (wr0) begin
      mem_d[waddr0] = wdata0;
    end
    if (wr1) begin
      mem_d[waddr1] = wdata1;
    end
    if (state_q == SWEEP) begin
      mem_d[cnt_q] = '0;
    end
    mem_d[0] = '0;
  end

  always_comb begin
    rdata = '0;
    for (int k = 0; k < NUM_RD; k++) begin : g_rd
      logic [ADDR_W-1:0] ra;
      logic [DATA_W-1:0] rv;
      ra = raddr[k*ADDR_W +: ADDR_W];
      rv = (ra == '0) ? '0 : mem_q[ra];
`ifdef REGFILE_BYPASS_EN
      if (ra != '0) begin
        if (wr1 && (waddr1 == ra)) begin
          rv = wdata1;
        end else if (wr0 && (waddr0 == ra)) begin
          rv = wdata0;
        end
      end
`endif
      rdata[k*DATA_W +: DATA_W] = rv;
    end
  end

endmodule
